eth_rx_perf_counters: RTL and testbench

ETH_RX_PERF_COUNTERS -- requirements
Module: eth_rx_perf_counters

---
 rtl/eth_rx_perf_if.sv | 33 +++
 rtl/eth_rx_perf_counters.sv | 151 +++++++++++++++
 tb/tb_eth_rx_perf_counters.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_perf_if.sv
// MAC receive-event and snapshot bus for eth_rx_perf_counters.
// master = MAC/host side driving frame events and snapshot requests; slave = counter block.
interface eth_rx_perf_if #(
    parameter int CNT_WIDTH      = 32,
    parameter int BYTE_CNT_WIDTH = 48
);
    // Every signal here is a single-cycle qualifier sampled on the rising clk edge.
    // There is no backpressure: rx_* and snap_req are always accepted, and
    // snap_valid pulses for exactly one cycle after snap_req.
    logic                      rx_start;
    logic                      rx_data_valid;
    logic [2:0]                rx_bytes_valid;
    logic                      rx_commit;
    logic                      rx_drop;
    logic                      snap_req;
    logic                      snap_clear;
    logic                      snap_valid;
    logic [CNT_WIDTH-1:0]      frames_ok;
    logic [CNT_WIDTH-1:0]      frames_dropped;
    logic [BYTE_CNT_WIDTH-1:0] bytes_ok;

    modport master (
        output rx_start, rx_data_valid, rx_bytes_valid, rx_commit, rx_drop,
        output snap_req, snap_clear,
        input  snap_valid, frames_ok, frames_dropped, bytes_ok
    );

    modport slave (
        input  rx_start, rx_data_valid, rx_bytes_valid, rx_commit, rx_drop,
        input  snap_req, snap_clear,
        output snap_valid, frames_ok, frames_dropped, bytes_ok
    );
endinterface

// File: rtl/eth_rx_perf_counters.sv
// Ethernet RX frame/byte performance counters with snapshot-and-clear readout.
// Optional macro ETH_RX_PERF_ACTIVITY_LED_EN enables a stretched frame-activity LED.
module eth_rx_perf_counters #(
    parameter int CNT_WIDTH      = 32,
    parameter int BYTE_CNT_WIDTH = 48,
    parameter int LED_STRETCH    = 12500000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            link_up,
    eth_rx_perf_if.slave    bus,
    output logic            activity_led,
    output logic [0:0]      fsm_state
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] IN_FRAME = 1'b1;

    logic [0:0]                state, state_next;
    logic [BYTE_CNT_WIDTH-1:0] acc, acc_next;
    logic [BYTE_CNT_WIDTH-1:0] word_bytes, frame_bytes;
    logic                      commit_evt, drop_evt;
    logic [CNT_WIDTH-1:0]      live_ok, live_drop, live_ok_next, live_drop_next;
    logic [BYTE_CNT_WIDTH-1:0] live_bytes, live_bytes_next;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic en);
        return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
    endfunction

    function automatic logic [BYTE_CNT_WIDTH-1:0] sat_add(input logic [BYTE_CNT_WIDTH-1:0] a,
                                                          input logic [BYTE_CNT_WIDTH-1:0] b);
        logic [BYTE_CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[BYTE_CNT_WIDTH] ? '1 : s[BYTE_CNT_WIDTH-1:0];
    endfunction

    // Out-of-range byte counts (0, 5..7) are taken as a full 4-byte word.
    always_comb begin
        word_bytes = '0;
        if (bus.rx_data_valid) begin
            if (bus.rx_bytes_valid == 3'd0 || bus.rx_bytes_valid > 3'd4)
                word_bytes = BYTE_CNT_WIDTH'(4);
            else
                word_bytes = {{(BYTE_CNT_WIDTH-3){1'b0}}, bus.rx_bytes_valid};
        end
    end

    assign frame_bytes = sat_add(acc, word_bytes);

    // Priority inside a frame: link loss > restart > drop > commit > data.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        commit_evt = 1'b0;
        drop_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (link_up && bus.rx_start) begin
                    state_next = IN_FRAME;
                    acc_next   = word_bytes;
                end
            end
            IN_FRAME: begin
                if (!link_up) begin
                    drop_evt   = 1'b1;
                    state_next = IDLE;
                    acc_next   = '0;
                end else if (bus.rx_start) begin
                    drop_evt = 1'b1;
                    acc_next = word_bytes;
                end else if (bus.rx_drop) begin
                    drop_evt   = 1'b1;
                    state_next = IDLE;
                    acc_next   = '0;
                end else if (bus.rx_commit) begin
                    commit_evt = 1'b1;
                    state_next = IDLE;
                    acc_next   = '0;
                end else begin
                    acc_next = frame_bytes;
                end
            end
            default: begin
                state_next = IDLE;
                acc_next   = '0;
            end
        endcase
    end

    assign live_ok_next    = sat_inc(live_ok, commit_evt);
    assign live_drop_next  = sat_inc(live_drop, drop_evt);
    assign live_bytes_next = commit_evt ? sat_add(live_bytes, frame_bytes) : live_bytes;
    assign fsm_state       = state;

    // Snapshot takes the post-event values so a same-cycle event lands in the
    // snapshot, while a clear discards it from the live counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            acc                <= '0;
            live_ok            <= '0;
            live_drop          <= '0;
            live_bytes         <= '0;
            bus.snap_valid     <= 1'b0;
            bus.frames_ok      <= '0;
            bus.frames_dropped <= '0;
            bus.bytes_ok       <= '0;
        end else begin
            state          <= state_next;
            acc            <= acc_next;
            bus.snap_valid <= bus.snap_req;
            if (bus.snap_req && bus.snap_clear) begin
                live_ok    <= '0;
                live_drop  <= '0;
                live_bytes <= '0;
            end else begin
                live_ok    <= live_ok_next;
                live_drop  <= live_drop_next;
                live_bytes <= live_bytes_next;
            end
            if (bus.snap_req) begin
                bus.frames_ok      <= live_ok_next;
                bus.frames_dropped <= live_drop_next;
                bus.bytes_ok       <= live_bytes_next;
            end
        end
    end

`ifdef ETH_RX_PERF_ACTIVITY_LED_EN
    localparam int TW = (LED_STRETCH < 1) ? 1 : $clog2(LED_STRETCH + 1);
    logic [TW-1:0] led_timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            led_timer <= '0;
        else if (commit_evt || drop_evt)
            led_timer <= TW'(LED_STRETCH);
        else if (led_timer != '0)
            led_timer <= led_timer - TW'(1);
    end

    assign activity_led = (led_timer != '0);
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            activity_led <= 1'b0;
        else
            activity_led <= link_up;
    end
`endif
endmodule

// File: tb/tb_eth_rx_perf_counters.sv
// Directed bench for eth_rx_perf_counters; snapshots are checked through an expected queue.
// Small CNT_WIDTH keeps counter saturation reachable; LED checks adapt to ETH_RX_PERF_ACTIVITY_LED_EN.
module tb_eth_rx_perf_counters;
    localparam int CW = 4;
    localparam int BW = 48;
    localparam int EW = CW + CW + BW;

    logic       clk;
    logic       rst;
    logic       link_up;
    logic       activity_led;
    logic [0:0] fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    eth_rx_perf_if #(.CNT_WIDTH(CW), .BYTE_CNT_WIDTH(BW)) bus ();

    eth_rx_perf_counters #(
        .CNT_WIDTH(CW), .BYTE_CNT_WIDTH(BW), .LED_STRETCH(10)
    ) dut (
        .clk(clk), .rst(rst), .link_up(link_up), .bus(bus),
        .activity_led(activity_led), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: snapshot contents checked when snap_valid pulses
    always @(negedge clk) begin
        if (!rst && bus.snap_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_snap", 64'd1, 64'd0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                chk("snap_frames_ok", 64'(bus.frames_ok), 64'(e[EW-1 -: CW]));
                chk("snap_frames_dropped", 64'(bus.frames_dropped), 64'(e[BW+CW-1 -: CW]));
                chk("snap_bytes_ok", 64'(bus.bytes_ok), 64'(e[BW-1:0]));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        bus.rx_start = 1'b1;
        tick();
        bus.rx_start = 1'b0;
    endtask

    task automatic word(input logic [2:0] n);
        bus.rx_data_valid  = 1'b1;
        bus.rx_bytes_valid = n;
        tick();
        bus.rx_data_valid  = 1'b0;
        bus.rx_bytes_valid = 3'd0;
    endtask

    task automatic commit();
        bus.rx_commit = 1'b1;
        tick();
        bus.rx_commit = 1'b0;
    endtask

    task automatic drop();
        bus.rx_drop = 1'b1;
        tick();
        bus.rx_drop = 1'b0;
    endtask

    task automatic snap(input logic clr, input logic [CW-1:0] eok, input logic [CW-1:0] edr,
                        input logic [BW-1:0] eby);
        exp_q.push_back({eok, edr, eby});
        bus.snap_req   = 1'b1;
        bus.snap_clear = clr;
        tick();
        bus.snap_req   = 1'b0;
        bus.snap_clear = 1'b0;
        chk("snap_valid_hi", 64'(bus.snap_valid), 64'd1);
        tick();
        chk("snap_valid_lo", 64'(bus.snap_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        link_up = 1'b1;
        bus.rx_start = 1'b0;
        bus.rx_data_valid = 1'b0;
        bus.rx_bytes_valid = 3'd0;
        bus.rx_commit = 1'b0;
        bus.rx_drop = 1'b0;
        bus.snap_req = 1'b0;
        bus.snap_clear = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_frames_ok", 64'(bus.frames_ok), 64'd0);
        chk("rst_frames_dropped", 64'(bus.frames_dropped), 64'd0);
        chk("rst_bytes_ok", 64'(bus.bytes_ok), 64'd0);
        chk("rst_snap_valid", 64'(bus.snap_valid), 64'd0);
        chk("rst_led", 64'(activity_led), 64'd0);
        chk("rst_fsm", 64'(fsm_state), 64'd0);
        rst = 1'b0;
        tick();

        // 15 full words plus a 2-byte tail = 62 bytes
        start_frame();
        chk("fsm_in_frame", 64'(fsm_state), 64'd1);
        for (int i = 0; i < 15; i++) word(3'd4);
        word(3'd2);
        commit();
        chk("fsm_idle_after_commit", 64'(fsm_state), 64'd0);
        snap(1'b1, 4'd1, 4'd0, 48'd62);

        // plain drop, then commit+drop together counts as drop
        start_frame();
        for (int i = 0; i < 5; i++) word(3'd4);
        drop();
        start_frame();
        for (int i = 0; i < 3; i++) word(3'd4);
        bus.rx_commit = 1'b1;
        bus.rx_drop   = 1'b1;
        tick();
        bus.rx_commit = 1'b0;
        bus.rx_drop   = 1'b0;
        snap(1'b1, 4'd0, 4'd2, 48'd0);

        // restart mid-frame, then stray events in IDLE
        start_frame();
        start_frame();
        commit();
        commit();
        word(3'd4);
        drop();
        snap(1'b1, 4'd1, 4'd1, 48'd0);

        // out-of-range byte counts as 4; commit carries the last word
        start_frame();
        word(3'd0);
        word(3'd5);
        word(3'd7);
        word(3'd1);
        bus.rx_data_valid  = 1'b1;
        bus.rx_bytes_valid = 3'd3;
        bus.rx_commit      = 1'b1;
        tick();
        bus.rx_data_valid  = 1'b0;
        bus.rx_bytes_valid = 3'd0;
        bus.rx_commit      = 1'b0;
        snap(1'b1, 4'd1, 4'd0, 48'd16);

        // snapshot+clear on the commit cycle
        start_frame();
        word(3'd4);
        exp_q.push_back({4'd1, 4'd0, 48'd4});
        bus.rx_commit  = 1'b1;
        bus.snap_req   = 1'b1;
        bus.snap_clear = 1'b1;
        tick();
        bus.rx_commit  = 1'b0;
        bus.snap_req   = 1'b0;
        bus.snap_clear = 1'b0;
        chk("snap_commit_valid_hi", 64'(bus.snap_valid), 64'd1);
        tick();
        snap(1'b0, 4'd0, 4'd0, 48'd0);

        // snapshot mid-frame leaves the accumulator alone
        start_frame();
        word(3'd4);
        snap(1'b0, 4'd0, 4'd0, 48'd0);
        chk("fsm_after_snap", 64'(fsm_state), 64'd1);
        word(3'd4);
        commit();
        snap(1'b1, 4'd1, 4'd0, 48'd8);

        // frame counter saturation
        for (int i = 0; i < 17; i++) begin
            start_frame();
            word(3'd1);
            commit();
        end
        snap(1'b1, 4'd15, 4'd0, 48'd17);

        // link loss mid-frame; start ignored while link down
        start_frame();
        word(3'd4);
        link_up = 1'b0;
        tick();
        chk("fsm_link_down", 64'(fsm_state), 64'd0);
`ifndef ETH_RX_PERF_ACTIVITY_LED_EN
        chk("led_follows_link_lo", 64'(activity_led), 64'd0);
`endif
        start_frame();
        chk("fsm_start_ignored", 64'(fsm_state), 64'd0);
        word(3'd4);
        commit();
        link_up = 1'b1;
        tick();
`ifndef ETH_RX_PERF_ACTIVITY_LED_EN
        chk("led_follows_link_hi", 64'(activity_led), 64'd1);
`endif
        snap(1'b1, 4'd0, 4'd1, 48'd0);

        // reset mid-frame discards the frame
        start_frame();
        word(3'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("fsm_after_mid_rst", 64'(fsm_state), 64'd0);
        commit();
        snap(1'b0, 4'd0, 4'd0, 48'd0);

`ifdef ETH_RX_PERF_ACTIVITY_LED_EN
        begin
            int high_cycles;
            repeat (15) tick();
            chk("led_idle_low", 64'(activity_led), 64'd0);
            start_frame();
            commit();
            high_cycles = 0;
            for (int i = 0; i < 30; i++) begin
                if (activity_led === 1'b1) high_cycles++;
                tick();
            end
            chk("led_stretch_cycles", 64'(high_cycles), 64'd10);
            chk("led_final_low", 64'(activity_led), 64'd0);
        end
`endif

        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
